fetch_unit: RTL and testbench
=============================

# fetch_unit

Requester-side controller for `program_memory`: a loader that writes program words into it, and an instruction fetcher that reads them back in sequence and hands them to decode. It owns the memory's address and the `PM_rd`/`PM_wr` strobes, and drives the shared bidirectional instruction bus only during writes. Fetched words pass through a small buffer to a valid/ready port on the decode stage, and decode can redirect the PC.

## Interface
- `IW`, default 67: instruction width; matches the program memory word.
- `AW`, default 5: address width; the memory holds 2^AW words.
- `BUF_DEPTH`, default 4: fetch buffer entries. Must be at least 3.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  requests load mode; only acted on in IDLE.
- `ld_valid`  in  1  load word offered.
- `ld_addr`  in  AW  load target address.
- `ld_data`  in  IW  load word.
- `ld_ready`  out  1  load word accepted when high together with `ld_valid`.
- `start`  in  1  begin fetching at PC 0; only acted on in IDLE.
- `halt`  in  1  stop fetching and return to IDLE.
- `redirect`  in  1  branch or redirect request from decode.
- `redirect_pc`  in  AW  redirect target.
- `out_valid`  out  1  instruction available to decode.
- `out_inst`  out  IW  instruction word.
- `out_pc`  out  AW  address the instruction was fetched from.
- `out_ready`  in  1  decode accepts the word at the clock edge.
- `pm_address`  out  AW  memory address; registered.
- `pm_rd`  out  1  memory read strobe; registered.
- `pm_wr`  out  1  memory write strobe; registered.
- `inst`  inout  IW  shared memory bus.

## Operation
- States are IDLE, LOAD, DRAIN and RUN. Reset goes to IDLE.
- IDLE:
  - `load_en` moves to LOAD.
  - Otherwise `start` moves to RUN. `load_en` wins if both are high.
- LOAD:
  - `ld_ready` is 1.
  - An accepted word is written on the next cycle: `pm_wr`=1, `pm_rd`=0, `pm_address`=`ld_addr`, `inst` driven with `ld_data`. The memory stores it at the following edge.
  - Throughput is one word per cycle.
  - When `load_en` is low, the state moves to DRAIN (`ld_ready`=0), completes any pending write, then returns to IDLE.
- RUN:
  - `pm_rd` is held at 1 and `pm_wr` at 0 for the whole state, so the memory keeps driving the bus in every capture cycle.
  - Each cycle either *issues* (`pm_address` takes the PC, the PC increments, and a tag is marked in flight) or repeats the previous address untagged.
  - An issue is allowed when occupancy + in-flight < `BUF_DEPTH`. In-flight ranges over 0..2.
  - Read data appears on `inst` in the cycle after the memory samples the address, and is captured into the buffer at the end of that cycle if its tag is live. Untagged data is ignored.
  - The PC wraps from 2^AW−1 to 0.
  - `redirect` flushes the buffer, kills both in-flight tags, loads `redirect_pc` into `pm_address` as an issue, and sets PC to `redirect_pc`+1. A pop in that cycle is discarded.
  - `halt` flushes everything, sets `pm_rd` to 0 and goes to IDLE. It has priority over `redirect`.
- Bus ownership: `inst` is driven only when `pm_wr`=1 and `pm_rd`=0, and is `z` otherwise. `pm_rd` and `pm_wr` are never both 1.
- Buffer:
  - FIFO; `out_*` reflect the head entry.
  - A pop happens when `out_valid` and `out_ready` are both high.
  - A capture and a pop in the same cycle keep the occupancy unchanged.

## Timing
- Reset values:
  - `pm_rd`, `pm_wr`, `pm_address` = 0.
  - `inst` = z.
  - `out_valid`, `out_inst`, `out_pc` = 0.
  - `ld_ready` = 0.
  - PC = 0, buffer empty, state IDLE.
- Asserting `rst` mid-operation aborts in the same instant: no partial write is issued after reset, and the bus is released immediately.
- Start latency: `start` sampled at edge E0; `pm_rd`=1 and address 0 after E0; memory samples at E1; word 0 captured at E2; `out_valid`=1 after E2.
- Sustains 1 instruction/cycle while `out_ready`=1.
- Redirect latency: the first new word has `out_valid` 2 cycles after the redirect edge.
- When the buffer is full, issue stops with no loss. Data already in flight is always accepted, because the issue rule reserves the space.

## Structure
- A shared package `fetch_pkg` holds:
  - the state enum;
  - the widths `IW` and `AW`;
  - opcode constants for the top 3 bits: ADD=000, SUB=001, MUL=010, DIV=011.
- One sub-module, `fetch_fifo`: parameterized depth and width, with push, pop, flush, occupancy, and registered head outputs.

## Test plan
- Load and read back: load words 0x11, 0x22 and 0x33 to addresses 0, 1 and 2; `start` with `out_ready`=1 → `out_inst` = 0x11, 0x22, 0x33 on consecutive cycles, `out_pc` = 0, 1, 2, first `out_valid` 2 cycles after `start`.
- Backpressure: hold `out_ready`=0 for 6 cycles after the first word → no entry dropped or duplicated, the next addresses stay in order, and occupancy never exceeds 4.
- Redirect: assert `redirect` with `redirect_pc`=20 while words 3 and 4 are in flight → the next `out_pc` is 20, then 21, and words 3 and 4 never appear.
- Wrap-around: `redirect_pc`=30 → `out_pc` is 30, 31, 0, 1.
- Bus contention check: an assertion that `pm_rd` and `pm_wr` are never both 1 and that `inst` is z whenever `pm_wr`=0, across load, DRAIN, RUN, `halt`, and `rst` asserted mid-LOAD.
- Simultaneous requests: `halt` and `redirect` in the same cycle → IDLE, `pm_rd`=0, `out_valid`=0. `load_en` and `start` together in IDLE → LOAD.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-memory fetch unit.
package fetch_pkg;

    localparam int IW = 67;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN
    } state_t;

    // Opcode field occupies the top three bits of an instruction word.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    function automatic logic [2:0] opcode_of(input logic [IW-1:0] word);
        return word[IW-1 -: 3];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO between instruction capture and decode; the head entry is held
// in registers so the consumer sees flop outputs.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [W-1:0]               head_data
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] wr_next;
    logic [CW-1:0] remaining;
    logic [CW-1:0] count_next;
    logic          pop_ok;
    logic          push_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop_ok     = pop && (count != '0);
        remaining  = count - CW'(pop_ok);
        push_ok    = push && (remaining != CW'(DEPTH));
        rd_next    = pop_ok ? bump(rd_ptr) : rd_ptr;
        wr_next    = push_ok ? bump(wr_ptr) : wr_ptr;
        count_next = remaining + CW'(push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When the FIFO drains to the entry being pushed, the head is loaded
    // straight from the push data since the array write lands this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (push_ok && (remaining == '0)) begin
                head_data <= push_data;
            end else if (count_next != '0) begin
                head_data <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Loader and sequential instruction fetcher in front of program_memory,
// delivering fetched words to decode through a valid/ready buffer.
module fetch_unit #(
    parameter int IW        = fetch_pkg::IW,
    parameter int AW        = fetch_pkg::AW,
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          start,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    output logic [IW-1:0] out_inst,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready,
    output logic [AW-1:0] pm_address,
    output logic          pm_rd,
    output logic          pm_wr,
    inout  logic [IW-1:0] inst
);
    import fetch_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH+1);

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] cap_pc;
    logic [IW-1:0] wr_data;
    logic          tag_addr;
    logic          tag_bus;
    logic [CW-1:0] occupancy;
    logic [CW+1:0] reserved;
    logic          can_issue;
    logic          flush;
    logic          push;
    logic          pop;

    // tag_addr: the address now on pm_address was an issue; tag_bus: the word
    // now on the bus belongs to a live issue and must be captured.
    always_comb begin
        reserved  = (CW+2)'(occupancy) + (CW+2)'(tag_addr) + (CW+2)'(tag_bus);
        can_issue = reserved < (CW+2)'(BUF_DEPTH);
        flush     = (state == ST_RUN) && (halt || redirect);
        push      = (state == ST_RUN) && tag_bus;
        pop       = out_valid && out_ready;
    end

    assign inst = (pm_wr && !pm_rd) ? wr_data : 'z;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (AW + IW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  ({cap_pc, inst}),
        .pop        (pop),
        .count      (occupancy),
        .head_valid (out_valid),
        .head_data  ({out_pc, out_inst})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= '0;
            cap_pc     <= '0;
            pm_address <= '0;
            pm_rd      <= 1'b0;
            pm_wr      <= 1'b0;
            wr_data    <= '0;
            ld_ready   <= 1'b0;
            tag_addr   <= 1'b0;
            tag_bus    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pm_wr    <= 1'b0;
                    tag_addr <= 1'b0;
                    tag_bus  <= 1'b0;
                    if (load_en) begin
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                    end else if (start) begin
                        state      <= ST_RUN;
                        pm_rd      <= 1'b1;
                        pm_address <= '0;
                        pc         <= AW'(1);
                        tag_addr   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    pm_wr <= ld_valid;
                    if (ld_valid) begin
                        pm_address <= ld_addr;
                        wr_data    <= ld_data;
                    end
                    if (!load_en) begin
                        ld_ready <= 1'b0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pm_wr <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_RUN: begin
                    tag_bus <= tag_addr;
                    cap_pc  <= pm_address;
                    if (halt) begin
                        state    <= ST_IDLE;
                        pm_rd    <= 1'b0;
                        tag_addr <= 1'b0;
                        tag_bus  <= 1'b0;
                    end else if (redirect) begin
                        pm_address <= redirect_pc;
                        pc         <= redirect_pc + AW'(1);
                        tag_addr   <= 1'b1;
                        tag_bus    <= 1'b0;
                    end else if (can_issue) begin
                        pm_address <= pc;
                        pc         <= pc + AW'(1);
                        tag_addr   <= 1'b1;
                    end else begin
                        tag_addr <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program_memory model on the shared bus, plus an
// expected-stream model of the instruction sequence delivered to decode.
module tb_fetch_unit;

    localparam int IW    = 67;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en, ld_valid, ld_ready;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          start, halt, redirect;
    logic [AW-1:0] redirect_pc;
    logic          out_valid, out_ready;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] pm_address;
    logic          pm_rd, pm_wr;
    wire  [IW-1:0] inst_bus;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .IW        (IW),
        .AW        (AW),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .pm_address  (pm_address),
        .pm_rd       (pm_rd),
        .pm_wr       (pm_wr),
        .inst        (inst_bus)
    );

    // program_memory: samples address/strobes at the edge, drives read data
    // during the following cycle.
    logic [IW-1:0] pmem [WORDS];
    logic [IW-1:0] pm_q;
    logic          pm_drive = 1'b0;

    initial begin
        for (int i = 0; i < WORDS; i++) pmem[i] = '0;
        pm_q = '0;
    end

    always @(posedge clk) begin
        if (pm_wr && !pm_rd) pmem[pm_address] <= inst_bus;
        pm_drive <= pm_rd;
        if (pm_rd) pm_q <= pmem[pm_address];
    end

    assign inst_bus = pm_drive ? pm_q : 'z;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bus_idle();
        return (inst_bus === {IW{1'bz}}) || (inst_bus === '0);
    endfunction

    always @(negedge clk) begin
        check("rd_wr_exclusive", 128'(pm_rd & pm_wr), 128'(0));
        if (!pm_wr && !pm_drive) check("bus_released", 128'(bus_idle()), 128'(1));
    end

    // Expected-stream model: decode must see consecutive PCs starting at
    // exp_pc, each carrying the loaded word for that address.
    logic [IW-1:0] ref_mem [WORDS];
    logic [AW-1:0] exp_pc  = '0;
    logic          running = 1'b0;

    task automatic step();
        logic          popping;
        logic [AW-1:0] lead;
        popping = running && out_valid && out_ready && !redirect && !halt;
        if (running) begin
            lead = pm_address - exp_pc;
            check("run_rd_held", 128'(pm_rd), 128'(1));
            check("issue_lead", 128'(lead <= AW'(DEPTH - 1)), 128'(1));
            if (out_valid) begin
                check("head_pc", 128'(out_pc), 128'(exp_pc));
                check("head_inst", 128'(out_inst), 128'(ref_mem[exp_pc]));
            end
        end
        @(posedge clk);
        #1;
        if (popping) exp_pc = exp_pc + AW'(1);
        if (running && halt) running = 1'b0;
        else if (running && redirect) exp_pc = redirect_pc;
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start   = 1'b0;
        running = 1'b1;
        exp_pc  = '0;
    endtask

    initial begin
        logic [IW-1:0] d;
        logic [AW-1:0] base;
        rst = 1'b1; load_en = 0; ld_valid = 0; ld_addr = '0; ld_data = '0;
        start = 0; halt = 0; redirect = 0; redirect_pc = '0; out_ready = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pm_rd", 128'(pm_rd), 128'(0));
        check("rst_pm_wr", 128'(pm_wr), 128'(0));
        check("rst_pm_address", 128'(pm_address), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_inst", 128'(out_inst), 128'(0));
        check("rst_out_pc", 128'(out_pc), 128'(0));
        check("rst_ld_ready", 128'(ld_ready), 128'(0));
        rst = 1'b0;

        // load_en and start together: load wins
        load_en = 1; start = 1;
        step();
        start = 0;
        check("load_wins_ready", 128'(ld_ready), 128'(1));
        check("load_wins_no_rd", 128'(pm_rd), 128'(0));

        for (int a = 0; a < WORDS; a++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 0;
                step();
                check("load_idle_no_wr", 128'(pm_wr), 128'(0));
            end
            case (a)
                0: d = IW'(67'h11);
                1: d = IW'(67'h22);
                2: d = IW'(67'h33);
                default: d = {3'($urandom), $urandom, $urandom};
            endcase
            check("ld_ready_load", 128'(ld_ready), 128'(1));
            ld_valid = 1; ld_addr = AW'(a); ld_data = d;
            if (a == WORDS - 1) load_en = 0;
            step();
            ref_mem[a] = d;
            check("wr_strobe", 128'(pm_wr), 128'(1));
            check("wr_no_rd", 128'(pm_rd), 128'(0));
            check("wr_addr", 128'(pm_address), 128'(a));
            check("wr_bus", 128'(inst_bus), 128'(d));
        end
        ld_valid = 0;
        check("drain_ready", 128'(ld_ready), 128'(0));
        step();
        check("drain_done_wr", 128'(pm_wr), 128'(0));
        check("idle_ready", 128'(ld_ready), 128'(0));

        // start latency and in-order readback
        out_ready = 1;
        begin_run();
        check("start_rd", 128'(pm_rd), 128'(1));
        check("start_addr", 128'(pm_address), 128'(0));
        check("start_e0_valid", 128'(out_valid), 128'(0));
        step();
        check("start_e1_valid", 128'(out_valid), 128'(0));
        step();
        check("start_e2_valid", 128'(out_valid), 128'(1));
        check("word0_pc", 128'(out_pc), 128'(0));
        check("word0_inst", 128'(out_inst), 128'(67'h11));
        step();
        check("word1_pc", 128'(out_pc), 128'(1));
        check("word1_inst", 128'(out_inst), 128'(67'h22));
        step();
        check("word2_pc", 128'(out_pc), 128'(2));
        check("word2_inst", 128'(out_inst), 128'(67'h33));

        // redirect while words 3 and 4 are in flight
        redirect = 1; redirect_pc = AW'(20);
        step();
        redirect = 0;
        check("redir_r0_valid", 128'(out_valid), 128'(0));
        step();
        check("redir_r1_valid", 128'(out_valid), 128'(0));
        step();
        check("redir_r2_valid", 128'(out_valid), 128'(1));
        check("redir_pc20", 128'(out_pc), 128'(20));
        step();
        check("redir_pc21", 128'(out_pc), 128'(21));

        // backpressure then full-rate drain
        out_ready = 0;
        repeat (6) step();
        check("stall_valid", 128'(out_valid), 128'(1));
        out_ready = 1;
        base = exp_pc;
        repeat (8) step();
        check("post_stall_rate", 128'(exp_pc - base), 128'(8));

        // wrap-around
        redirect = 1; redirect_pc = AW'(30);
        step();
        redirect = 0;
        step();
        step();
        check("wrap_pc30", 128'(out_pc), 128'(30));
        step();
        check("wrap_pc31", 128'(out_pc), 128'(31));
        step();
        check("wrap_pc0", 128'(out_pc), 128'(0));
        check("wrap_inst0", 128'(out_inst), 128'(67'h11));
        step();
        check("wrap_pc1", 128'(out_pc), 128'(1));

        // halt has priority over redirect
        halt = 1; redirect = 1; redirect_pc = AW'(5);
        step();
        halt = 0; redirect = 0;
        check("halt_rd", 128'(pm_rd), 128'(0));
        check("halt_valid", 128'(out_valid), 128'(0));
        step();
        check("idle_rd", 128'(pm_rd), 128'(0));
        check("idle_valid", 128'(out_valid), 128'(0));

        // randomized run with backpressure and redirects
        begin_run();
        for (int c = 0; c < 600; c++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = AW'($urandom);
            step();
        end
        redirect = 0;
        halt = 1;
        step();
        halt = 0;
        check("rand_halt_valid", 128'(out_valid), 128'(0));

        // reset in the middle of a load write
        load_en = 1;
        step();
        ld_valid = 1; ld_addr = AW'(7); ld_data = ~ref_mem[7];
        step();
        ld_valid = 0;
        check("midload_wr", 128'(pm_wr), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("midload_rst_wr", 128'(pm_wr), 128'(0));
        check("midload_rst_ready", 128'(ld_ready), 128'(0));
        check("midload_rst_bus", 128'(bus_idle()), 128'(1));
        load_en = 0;
        @(posedge clk);
        #1;
        check("midload_no_write", 128'(pmem[7]), 128'(ref_mem[7]));
        rst = 1'b0;
        step();

        out_ready = 1;
        begin_run();
        repeat (14) step();
        check("final_progress", 128'(exp_pc >= AW'(8)), 128'(1));
        halt = 1;
        step();
        halt = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
